// File: rtl/bcd_alarm_timer.sv
// bcd_alarm_timer: MM:SS BCD up/down timer with NUM_CH armed alarm channels
//
// Ports:
//   clk          system clock, all state on posedge
//   reset        asynchronous active-low reset
//   run          count advances on tick when high
//   dir          0 = count up, 1 = count down (saturates at 00:00)
//   load         pulse: count <= preset if preset is valid BCD MM:SS
//   preset       BCD {m10,m1,s10,s1}
//   inc          pulse: setpoint[sel] += 1 s (BCD, 59:59 wraps)
//   sel          channel for inc and setpoint_out
//   arm          per-channel alarm enable (level)
//   ack          pulse: silence all ringing channels
//   snooze       (ALARM_SNOOZE_EN only) pulse: snooze ringing channels
//   count        current BCD count
//   setpoint_out setpoint of channel sel, 0000 when sel >= NUM_CH
//   ringing      per-channel alarm active
//   tick         one-cycle pulse per second
//   zero         count == 0000
//
// Build option: define ALARM_SNOOZE_EN to add the snooze input and the
// SNOOZE_SECS parameter.
module bcd_alarm_timer #(
    parameter int TICK_DIV  = 50_000_000,
    parameter int NUM_CH    = 2,
    parameter int CH_W      = 1,
    parameter int RING_SECS = 30
`ifdef ALARM_SNOOZE_EN
    ,
    parameter int SNOOZE_SECS = 60
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              dir,
    input  logic              load,
    input  logic [15:0]       preset,
    input  logic              inc,
    input  logic [CH_W-1:0]   sel,
    input  logic [NUM_CH-1:0] arm,
    input  logic              ack,
`ifdef ALARM_SNOOZE_EN
    input  logic              snooze,
`endif
    output logic [15:0]       count,
    output logic [15:0]       setpoint_out,
    output logic [NUM_CH-1:0] ringing,
    output logic              tick,
    output logic              zero
);
    localparam int PW = $clog2(TICK_DIV);

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [3:0] m10, m1, s10, s1;
        {m10, m1, s10, s1} = v;
        if (s1 != 4'd9) s1 = s1 + 4'd1;
        else begin
            s1 = '0;
            if (s10 != 4'd5) s10 = s10 + 4'd1;
            else begin
                s10 = '0;
                if (m1 != 4'd9) m1 = m1 + 4'd1;
                else begin
                    m1  = '0;
                    m10 = (m10 == 4'd5) ? '0 : m10 + 4'd1;
                end
            end
        end
        return {m10, m1, s10, s1};
    endfunction

    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [3:0] m10, m1, s10, s1;
        {m10, m1, s10, s1} = v;
        if (v == '0) return v;
        if (s1 != '0) s1 = s1 - 4'd1;
        else begin
            s1 = 4'd9;
            if (s10 != '0) s10 = s10 - 4'd1;
            else begin
                s10 = 4'd5;
                if (m1 != '0) m1 = m1 - 4'd1;
                else begin
                    m1  = 4'd9;
                    m10 = m10 - 4'd1;
                end
            end
        end
        return {m10, m1, s10, s1};
    endfunction

    logic [PW-1:0]             pre_q, pre_d;
    logic                      tick_q, tick_d;
    logic [15:0]               count_q, count_d;
    logic                      chg_q, chg_d;
    logic [NUM_CH-1:0][15:0]   sp_q, sp_d;
    logic [NUM_CH-1:0]         cmp_q, cmp_d;
    logic [NUM_CH-1:0]         ring_q, ring_d;
    logic [NUM_CH-1:0][7:0]    rc_q, rc_d;
    logic [NUM_CH-1:0]         set_c, exp_c;
    logic [NUM_CH-1:0]         snz, sdone;
    logic                      load_ok;

    always_comb begin
        load_ok = load && preset[15:12] <= 4'd5 && preset[11:8] <= 4'd9 &&
                  preset[7:4] <= 4'd5 && preset[3:0] <= 4'd9;
        pre_d   = (load_ok || pre_q == PW'(TICK_DIV - 1)) ? '0 : pre_q + PW'(1);
        tick_d  = pre_q == PW'(TICK_DIV - 1);
        count_d = load_ok ? preset :
                  (tick_q && run) ? (dir ? bcd_dec(count_q) : bcd_inc(count_q)) : count_q;
        // A saturated down-count is not a change, so a held 00:00 match rings once.
        chg_d   = load_ok || (tick_q && run && !(dir && count_q == '0));
        sp_d    = sp_q;
        cmp_d   = '0;
        set_c   = '0;
        exp_c   = '0;
        ring_d  = '0;
        rc_d    = rc_q;
        for (int c = 0; c < NUM_CH; c++) begin
            cmp_d[c]  = count_q == sp_q[c];
            sp_d[c]   = (inc && int'(sel) == c) ? bcd_inc(sp_q[c]) : sp_q[c];
            // Match edge: compare newly true, or count just moved onto the value.
            set_c[c]  = arm[c] && cmp_d[c] && !ring_q[c] && (!cmp_q[c] || chg_q);
            exp_c[c]  = ring_q[c] && tick_q && rc_q[c] == 8'(RING_SECS - 1);
            ring_d[c] = set_c[c] || (sdone[c] && arm[c] && !ack) ||
                        (ring_q[c] && arm[c] && !ack && !exp_c[c] && !snz[c]);
            rc_d[c]   = (set_c[c] || sdone[c]) ? '0 :
                        (ring_q[c] && tick_q) ? rc_q[c] + 8'd1 : rc_q[c];
        end
    end

    // cmp_q resets high: count and setpoints both clear to 0000, so there is
    // no fresh match edge on reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_q   <= '0;
            tick_q  <= 1'b0;
            count_q <= '0;
            chg_q   <= 1'b0;
            sp_q    <= '0;
            cmp_q   <= '1;
            ring_q  <= '0;
            rc_q    <= '0;
        end else begin
            pre_q   <= pre_d;
            tick_q  <= tick_d;
            count_q <= count_d;
            chg_q   <= chg_d;
            sp_q    <= sp_d;
            cmp_q   <= cmp_d;
            ring_q  <= ring_d;
            rc_q    <= rc_d;
        end
    end

`ifdef ALARM_SNOOZE_EN
    logic [NUM_CH-1:0]       sn_q, sn_d;
    logic [NUM_CH-1:0][15:0] sc_q, sc_d;

    always_comb begin
        snz   = '0;
        sdone = '0;
        sn_d  = '0;
        sc_d  = sc_q;
        for (int c = 0; c < NUM_CH; c++) begin
            snz[c]   = snooze && ring_q[c];
            sdone[c] = sn_q[c] && tick_q && sc_q[c] == 16'(SNOOZE_SECS - 1);
            // A pending snooze ends on expiry, a fresh ring, ack or disarm.
            sn_d[c]  = (snz[c] || (sn_q[c] && !ring_q[c] && !sdone[c])) && !ack && arm[c];
            sc_d[c]  = snz[c] ? '0 : (sn_q[c] && tick_q) ? sc_q[c] + 16'd1 : sc_q[c];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sn_q <= '0;
            sc_q <= '0;
        end else begin
            sn_q <= sn_d;
            sc_q <= sc_d;
        end
    end
`else
    assign snz   = '0;
    assign sdone = '0;
`endif

    always_comb begin
        setpoint_out = '0;
        for (int c = 0; c < NUM_CH; c++)
            setpoint_out = (int'(sel) == c) ? sp_q[c] : setpoint_out;
    end

    assign count   = count_q;
    assign ringing = ring_q;
    assign tick    = tick_q;
    assign zero    = count_q == '0;
endmodule

// File: tb/tb_bcd_alarm_timer.sv
// tb_bcd_alarm_timer: directed + random check of bcd_alarm_timer against a seconds-based model
module tb_bcd_alarm_timer;
    localparam int TD = 4, NC = 2, CW = 2, RS = 3;

    logic          clk = 0, reset = 0, run = 0, dir = 0, load = 0, inc = 0, ack = 0;
    logic [15:0]   preset = '0;
    logic [CW-1:0] sel = '0;
    logic [NC-1:0] arm = '0;
`ifdef ALARM_SNOOZE_EN
    logic          snooze = 0;
`endif
    logic [15:0]   count, setpoint_out;
    logic [NC-1:0] ringing;
    logic          tick, zero;
    int            n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    bcd_alarm_timer #(.TICK_DIV(TD), .NUM_CH(NC), .CH_W(CW), .RING_SECS(RS)) dut (
        .clk(clk), .reset(reset), .run(run), .dir(dir), .load(load), .preset(preset),
        .inc(inc), .sel(sel), .arm(arm), .ack(ack),
`ifdef ALARM_SNOOZE_EN
        .snooze(snooze),
`endif
        .count(count), .setpoint_out(setpoint_out), .ringing(ringing), .tick(tick), .zero(zero)
    );

    int m_pre, m_secs, m_sp[NC], m_rc[NC];
    bit m_tick, m_chg, m_ring[NC], m_prev[NC];

    function automatic int bcd2s(logic [15:0] b);
        return (int'(b[15:12]) * 10 + int'(b[11:8])) * 60 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [15:0] s2bcd(int s);
        int m = s / 60, x = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
    endfunction

    function automatic bit valid(logic [15:0] b);
        return b[15:12] <= 5 && b[11:8] <= 9 && b[7:4] <= 5 && b[3:0] <= 9;
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pre = 0; m_secs = 0; m_tick = 0; m_chg = 0;
        for (int c = 0; c < NC; c++) begin
            m_sp[c] = 0; m_rc[c] = 0; m_ring[c] = 0; m_prev[c] = 1;
        end
    endtask

    task automatic model_step();
        bit ok = load && valid(preset);
        int n_secs = ok ? bcd2s(preset) :
                     (m_tick && run) ? (dir ? (m_secs > 0 ? m_secs - 1 : 0) : (m_secs + 1) % 3600) : m_secs;
        for (int c = 0; c < NC; c++) begin
            bit eq = m_secs == m_sp[c];
            if (arm[c] && eq && !m_ring[c] && (!m_prev[c] || m_chg)) begin
                m_ring[c] = 1; m_rc[c] = 0;
            end else if (m_ring[c]) begin
                if (ack || !arm[c]) m_ring[c] = 0;
                else if (m_tick) begin
                    m_rc[c]++;
                    if (m_rc[c] == RS) m_ring[c] = 0;
                end
            end
            m_prev[c] = eq;
            if (inc && int'(sel) == c) m_sp[c] = (m_sp[c] + 1) % 3600;
        end
        m_chg  = ok || n_secs != m_secs;
        m_secs = n_secs;
        m_tick = m_pre == TD - 1;
        m_pre  = (ok || m_pre == TD - 1) ? 0 : m_pre + 1;
    endtask

    task automatic check_outs();
        logic [NC-1:0] r;
        logic [15:0] sp = '0;
        for (int c = 0; c < NC; c++) r[c] = m_ring[c];
        if (int'(sel) < NC) sp = s2bcd(m_sp[int'(sel)]);
        chk("count", count, s2bcd(m_secs));
        chk("setpoint_out", setpoint_out, sp);
        chk("ringing", ringing, r);
        chk("tick", tick, m_tick);
        chk("zero", zero, m_secs == 0);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outs();
    endtask

    initial begin
        int n, c0, ch;
        reset = 0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_count", count, 0);
        chk("rst_zero", zero, 1);
        chk("rst_ring", ringing, 0);
        reset = 1;
        n = 0;
        do begin step(); n++; end while (!tick && n < 10);
        chk("first_tick_lat", n, TD);

        preset = 16'h5958; load = 1; run = 1; dir = 0;
        step(); load = 0;
        repeat (9) step();
        chk("wrap_count", count, 0);
        chk("wrap_zero", zero, 1);

        preset = 16'h0002; load = 1; dir = 1;
        step(); load = 0;
        repeat (9) step();
        chk("down_zero", count, 0);
        repeat (8) step();
        chk("down_sat", count, 0);

        run = 0; dir = 0; preset = 16'h0000; load = 1;
        step(); load = 0; sel = 1;
        repeat (5) begin inc = 1; step(); inc = 0; step(); end
        chk("sp1_set", setpoint_out, 16'h0005);
        arm = 2'b10; run = 1;
        n = 0;
        while (!ringing[1] && n < 60) begin step(); n++; end
        chk("ring_rise", ringing, 2'b10);
        chk("ring_at_count", count, 16'h0005);
        n = 0;
        while (ringing[1] && n < 40) begin step(); n++; end
        chk("ring_timeout", ringing, 0);
        preset = 16'h0004; load = 1;
        step(); load = 0;
        n = 0;
        while (count != 16'h0005 && n < 40) begin step(); n++; end
        ack = 1; step(); ack = 0;
        chk("ack_vs_set", ringing[1], 1);
        ack = 1; step(); ack = 0;
        chk("ack_clear", ringing, 0);

        run = 0; step();
        c0 = count;
        preset = 16'h0070; load = 1;
        step(); load = 0;
        chk("bad_preset", count, c0);
        sel = 2; inc = 1; step(); inc = 0;
        chk("sel_oob_sp", setpoint_out, 0);
        sel = 1; step();
        chk("sp1_kept", setpoint_out, 16'h0005);

        arm = 2'b11; run = 1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                reset = 0; #1;
                chk("async_rst_count", count, 0);
                chk("async_rst_ring", ringing, 0);
                chk("async_rst_tick", tick, 0);
                model_reset();
                @(negedge clk);
                reset = 1;
                continue;
            end
            run  = $urandom_range(0, 9) != 0;
            if ($urandom_range(0, 49) == 0) dir = ~dir;
            load = $urandom_range(0, 15) == 0;
            ch   = $urandom_range(0, NC - 1);
            case ($urandom_range(0, 3))
                0:       preset = 16'($urandom);
                1:       preset = s2bcd($urandom_range(0, 3599));
                default: preset = s2bcd((m_sp[ch] + 3600 - $urandom_range(0, 3)) % 3600);
            endcase
            inc = $urandom_range(0, 7) == 0;
            sel = CW'($urandom);
            if ($urandom_range(0, 39) == 0) arm = NC'($urandom);
            ack = $urandom_range(0, 29) == 0;
            step();
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
